// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 16x16 signed multiplier among N_REQ requesters, with a tag pipeline that routes each product back to its owner.
// Optional per-requester grant counters are enabled by defining MULT_SHARE_STATS_EN.
module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 5,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  output logic                  mul_reset,
  input  logic [31:0]           mul_y,
`ifdef MULT_SHARE_STATS_EN
  input  logic                  stat_clr,
  output logic [16*N_REQ-1:0]   stat_cnt,
`endif
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_y,
  output logic                  busy
);

  localparam int DATA_W = 16;

  logic [ID_W-1:0] last_id;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W:0]   scan;
  logic [ID_W-1:0] scan_id;

  logic            tag_vld_p [MUL_LAT];
  logic [ID_W-1:0] tag_id_p  [MUL_LAT];
  logic            any_tag;

  assign mul_reset = reset;

  // Arbitration: scan from the requester after the last winner, wrapping once around.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    scan_id = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan = {1'b0, last_id} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(N_REQ))
        scan = scan - (ID_W+1)'(N_REQ);
      scan_id = scan[ID_W-1:0];
      if (!gnt_vld && !reset && req[scan_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_id;
      end
    end
    if (gnt_vld)
      gnt[gnt_id] = 1'b1;
  end

  // Issue stage (p0) and tag valid shift through the multiplier latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_id <= ID_W'(N_REQ-1);
      mul_a   <= '0;
      mul_b   <= '0;
      for (int i = 0; i < MUL_LAT; i++)
        tag_vld_p[i] <= 1'b0;
    end else begin
      if (gnt_vld) begin
        last_id <= gnt_id;
        mul_a   <= req_a[DATA_W*gnt_id +: DATA_W];
        mul_b   <= req_b[DATA_W*gnt_id +: DATA_W];
      end else begin
        mul_a   <= '0;
        mul_b   <= '0;
      end
      tag_vld_p[0] <= gnt_vld;
      for (int i = 1; i < MUL_LAT; i++)
        tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  // Tag ids ride alongside the valids; their validity is carried by tag_vld_p.
  always_ff @(posedge clk) begin
    tag_id_p[0] <= gnt_id;
    for (int i = 1; i < MUL_LAT; i++)
      tag_id_p[i] <= tag_id_p[i-1];
  end

  // Return stage: capture the product as the owning tag leaves the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else if (tag_vld_p[MUL_LAT-1]) begin
      rsp_valid <= N_REQ'(1) << tag_id_p[MUL_LAT-1];
      rsp_y     <= mul_y;
    end else begin
      rsp_valid <= '0;
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < MUL_LAT; i++)
      any_tag = any_tag | tag_vld_p[i];
  end

  assign busy = any_tag | (|rsp_valid);

`ifdef MULT_SHARE_STATS_EN
  logic [15:0] stat_q [N_REQ];

  // Clear takes precedence over a coincident grant.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      for (int i = 0; i < N_REQ; i++)
        stat_q[i] <= '0;
    end else if (gnt_vld && stat_q[gnt_id] != 16'hFFFF) begin
      stat_q[gnt_id] <= stat_q[gnt_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_cnt[16*g +: 16] = stat_q[g];
  end
`endif

endmodule
